best_move_select: RTL and testbench
===================================

# best_move_select

Sequential stage directly downstream of the 64-square score arbiter tree. It runs one search as a series of passes, one per candidate source piece. For each pass it requests an arbiter evaluation, receives the winning (score, destination) pair, and keeps the best move across all passes. It then presents the chosen move to the move-execution logic over a valid/ready handshake.

## Interface
- SCORE_W, 6, width of arbiter score.
- POS_W, 6, width of square index (0–63).
- MAX_PASSES, 16, maximum passes per search; num_passes is clamped to this value.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a search; sampled only in IDLE.
- num_passes  in  5  pass count, sampled with start.
- abort  in  1  synchronous; returns to IDLE from any state.
- pass_req  out  1  one-cycle request to the upstream evaluator to run the next pass.
- pass_idx  out  4  index of the pass being requested or awaited.
- arb_valid  in  1  arbiter result strobe for the current pass.
- arb_score  in  SCORE_W  best score of this pass; 0 means no legal destination.
- arb_pos  in  POS_W  destination square of that score.
- arb_src  in  POS_W  source square of the piece evaluated this pass.
- move_valid  out  1  chosen move available.
- move_ready  in  1  consumer accepts the move.
- move_src  out  POS_W  chosen source square.
- move_dst  out  POS_W  chosen destination square.
- move_score  out  SCORE_W  chosen score.
- no_move  out  1  qualifies move_valid; 1 means no legal move was found.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, REQ, WAIT, PRESENT.
- IDLE:
  - On start, latch N = min(num_passes, MAX_PASSES).
  - Clear best_score to 0, best_src to 0, best_dst to 0 and pass_cnt to 0.
  - If N == 0, go to PRESENT. Otherwise go to REQ.
- REQ: pass_req = 1 and pass_idx = pass_cnt for exactly one cycle, then go to WAIT.
- WAIT:
  - On arb_valid, if arb_score > best_score (strict), load best from {arb_score, arb_src, arb_pos}. On equal scores the earlier pass is kept.
  - Then, if pass_cnt == N-1, go to PRESENT. Otherwise increment pass_cnt and go to REQ.
- PRESENT:
  - move_valid = 1; move_* = best registers; no_move = (best_score == 0).
  - Outputs are held stable until move_ready is sampled high, then go to IDLE.
- arb_valid outside WAIT is ignored and has no state change.
- start outside IDLE is ignored. A start coincident with move acceptance is also ignored.
- abort has priority over every transition. Next cycle: state IDLE, pass_req 0, move_valid 0. Best registers are not cleared until the next start.
- Scores are compared unsigned at SCORE_W width. pass_cnt is 4 bits and never wraps, because N ≤ MAX_PASSES = 16.

## Timing
- Reset values: state IDLE; pass_req 0, pass_idx 0, move_valid 0, move_src 0, move_dst 0, move_score 0, no_move 0, busy 0.
- All outputs are registered (Moore) with no combinational path from inputs to outputs.
- start at cycle 0 → busy = 1 and pass_req = 1 in cycle 1.
- The earliest legal arb_valid is cycle 2 (one cycle after pass_req). Any upstream latency ≥ 1 is tolerated.
- arb_valid at cycle t, not the last pass → next pass_req at t+1.
- arb_valid at cycle t, last pass → move_valid at t+1.
- Minimum search length: 2N+1 cycles from start to move_valid.
- N == 0: move_valid = 1 and no_move = 1 at cycle 1.
- Handshake: a transfer occurs in a cycle where move_valid && move_ready. In the following cycle move_valid = 0 and busy = 0.
- If move_ready is held high continuously, move_valid is high for exactly one cycle.
- rst_n low mid-search: all outputs go to reset values immediately (asynchronously), and any pending pass is discarded.

## Test plan
- Reset and idle: assert rst_n = 0 mid-WAIT → pass_req, move_valid and busy go to 0 immediately. After release, no pass_req appears without a start.
- Three-pass search:
  - Stimulus: N = 3; passes return (score, src, dst) = (5, 12, 20), (9, 1, 18), (7, 6, 21); move_ready = 1.
  - Required: move_src = 1, move_dst = 18, move_score = 9, no_move = 0, move_valid asserted 1 cycle after the third arb_valid.
- Tie and zero:
  - Stimulus: N = 2, passes (4, 3, 11) then (4, 8, 30).
  - Required: move_src = 3, move_dst = 11 (earlier pass wins).
  - Separately, N = 2 with both scores 0 → no_move = 1, move_score = 0.
- Backpressure: hold move_ready = 0 for 5 cycles in PRESENT → move_* stable and move_valid = 1 throughout. A start pulse during that window is ignored. Raise move_ready → IDLE next cycle.
- Boundaries:
  - num_passes = 0 → move_valid = 1 and no_move = 1 at cycle 1.
  - num_passes = 20 → exactly 16 pass_req pulses, with pass_idx running 0 through 15.
- Abort and stray strobes:
  - abort in WAIT of pass 2 → IDLE next cycle with no move_valid.
  - arb_valid pulses in IDLE or REQ leave all state unchanged.

Source files
------------

// File: rtl/best_move_select.rtl.sv
// best_move_select
// Runs one move search as a sequence of arbiter passes (one per candidate
// source piece), keeps the strictly-best (score, src, dst) seen so far, and
// offers the winner to the move-execution logic on a valid/ready handshake.
// Every output is a flop fed from the next-state logic, so nothing reaches an
// output combinationally from an input.

module best_move_select #(
  parameter int SCORE_W    = 6,
  parameter int POS_W      = 6,
  parameter int MAX_PASSES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [4:0]         num_passes,
  input  logic               abort,
  output logic               pass_req,
  output logic [3:0]         pass_idx,
  input  logic               arb_valid,
  input  logic [SCORE_W-1:0] arb_score,
  input  logic [POS_W-1:0]   arb_pos,
  input  logic [POS_W-1:0]   arb_src,
  output logic               move_valid,
  input  logic               move_ready,
  output logic [POS_W-1:0]   move_src,
  output logic [POS_W-1:0]   move_dst,
  output logic [SCORE_W-1:0] move_score,
  output logic               no_move,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_PRESENT = 2'd3;

  localparam logic [4:0] MAX_N = 5'(MAX_PASSES);

  logic [1:0]         state_r,      state_nxt_s;
  logic [4:0]         n_r,          n_nxt_s;
  logic [3:0]         cnt_r,        cnt_nxt_s;
  logic [SCORE_W-1:0] best_score_r, best_score_nxt_s;
  logic [POS_W-1:0]   best_src_r,   best_src_nxt_s;
  logic [POS_W-1:0]   best_dst_r,   best_dst_nxt_s;
  logic               last_pass_s;

  // The current pass is the final one when the counter reaches N-1 (N >= 1 in WAIT).
  assign last_pass_s = ({1'b0, cnt_r} == (n_r - 5'd1));

  // Next-state logic: abort wins over everything, then the per-state transitions.
  always_comb begin
    state_nxt_s      = state_r;
    n_nxt_s          = n_r;
    cnt_nxt_s        = cnt_r;
    best_score_nxt_s = best_score_r;
    best_src_nxt_s   = best_src_r;
    best_dst_nxt_s   = best_dst_r;
    if (abort) begin
      // Best registers are deliberately left intact until the next start.
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            n_nxt_s          = (num_passes > MAX_N) ? MAX_N : num_passes;
            cnt_nxt_s        = 4'd0;
            best_score_nxt_s = '0;
            best_src_nxt_s   = '0;
            best_dst_nxt_s   = '0;
            if (num_passes == 5'd0) begin
              state_nxt_s = ST_PRESENT;
            end else begin
              state_nxt_s = ST_REQ;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_REQ: begin
          state_nxt_s = ST_WAIT;
        end
        ST_WAIT: begin
          if (arb_valid) begin
            // Strict compare: on a tie the earlier pass keeps the slot.
            if (arb_score > best_score_r) begin
              best_score_nxt_s = arb_score;
              best_src_nxt_s   = arb_src;
              best_dst_nxt_s   = arb_pos;
            end else begin
              best_score_nxt_s = best_score_r;
            end
            if (last_pass_s) begin
              state_nxt_s = ST_PRESENT;
            end else begin
              cnt_nxt_s   = cnt_r + 4'd1;
              state_nxt_s = ST_REQ;
            end
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_PRESENT: begin
          // A start arriving with the acceptance is dropped: we are not in IDLE.
          if (move_ready) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_PRESENT;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Internal search state: FSM, clamped pass count, pass counter and best move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      n_r          <= 5'd0;
      cnt_r        <= 4'd0;
      best_score_r <= '0;
      best_src_r   <= '0;
      best_dst_r   <= '0;
    end else begin
      state_r      <= state_nxt_s;
      n_r          <= n_nxt_s;
      cnt_r        <= cnt_nxt_s;
      best_score_r <= best_score_nxt_s;
      best_src_r   <= best_src_nxt_s;
      best_dst_r   <= best_dst_nxt_s;
    end
  end

  // Registered outputs, decoded from next-state so they line up with the state flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_req   <= 1'b0;
      pass_idx   <= 4'd0;
      move_valid <= 1'b0;
      move_src   <= '0;
      move_dst   <= '0;
      move_score <= '0;
      no_move    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      pass_req   <= (state_nxt_s == ST_REQ);
      pass_idx   <= cnt_nxt_s;
      move_valid <= (state_nxt_s == ST_PRESENT);
      move_src   <= best_src_nxt_s;
      move_dst   <= best_dst_nxt_s;
      move_score <= best_score_nxt_s;
      no_move    <= (state_nxt_s == ST_PRESENT) && (best_score_nxt_s == '0);
      busy       <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_best_move_select.sv
// Directed self-checking bench for best_move_select.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.

module tb_best_move_select;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] num_passes;
  logic       abort;
  logic       pass_req;
  logic [3:0] pass_idx;
  logic       arb_valid;
  logic [5:0] arb_score;
  logic [5:0] arb_pos;
  logic [5:0] arb_src;
  logic       move_valid;
  logic       move_ready;
  logic [5:0] move_src;
  logic [5:0] move_dst;
  logic [5:0] move_score;
  logic       no_move;
  logic       busy;

  int n_cmp;
  int n_bad;

  best_move_select #(.SCORE_W(6), .POS_W(6), .MAX_PASSES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_passes (num_passes),
    .abort      (abort),
    .pass_req   (pass_req),
    .pass_idx   (pass_idx),
    .arb_valid  (arb_valid),
    .arb_score  (arb_score),
    .arb_pos    (arb_pos),
    .arb_src    (arb_src),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .move_src   (move_src),
    .move_dst   (move_dst),
    .move_score (move_score),
    .no_move    (no_move),
    .busy       (busy)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in a REQ cycle: wait one cycle (WAIT), strobe a result, consume it.
  task automatic do_pass(input logic [5:0] sc, input logic [5:0] src, input logic [5:0] dst);
    tick();
    arb_valid = 1'b1;
    arb_score = sc;
    arb_src   = src;
    arb_pos   = dst;
    tick();
    arb_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] n);
    start      = 1'b1;
    num_passes = n;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0; start = 1'b0; num_passes = 5'd0; abort = 1'b0;
    arb_valid = 1'b0; arb_score = 6'd0; arb_pos = 6'd0; arb_src = 6'd0;
    move_ready = 1'b1;
    #12;
    chk("rst_pass_req",   32'(pass_req),   32'd0);
    chk("rst_pass_idx",   32'(pass_idx),   32'd0);
    chk("rst_move_valid", 32'(move_valid), 32'd0);
    chk("rst_move_score", 32'(move_score), 32'd0);
    chk("rst_no_move",    32'(no_move),    32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Three-pass search, minimum latency 2N+1.
    pulse_start(5'd3);
    chk("p3_busy_c1", 32'(busy),     32'd1);
    chk("p3_req_c1",  32'(pass_req), 32'd1);
    chk("p3_idx0",    32'(pass_idx), 32'd0);
    do_pass(6'd5, 6'd12, 6'd20);
    chk("p3_req1",    32'(pass_req), 32'd1);
    chk("p3_idx1",    32'(pass_idx), 32'd1);
    do_pass(6'd9, 6'd1, 6'd18);
    chk("p3_idx2",    32'(pass_idx), 32'd2);
    do_pass(6'd7, 6'd6, 6'd21);
    chk("p3_valid",   32'(move_valid), 32'd1);
    chk("p3_src",     32'(move_src),   32'd1);
    chk("p3_dst",     32'(move_dst),   32'd18);
    chk("p3_score",   32'(move_score), 32'd9);
    chk("p3_no_move", 32'(no_move),    32'd0);
    tick();
    chk("p3_valid_drop", 32'(move_valid), 32'd0);
    chk("p3_busy_drop",  32'(busy),       32'd0);

    // Tie: earlier pass wins.
    pulse_start(5'd2);
    do_pass(6'd4, 6'd3, 6'd11);
    do_pass(6'd4, 6'd8, 6'd30);
    chk("tie_valid", 32'(move_valid), 32'd1);
    chk("tie_src",   32'(move_src),   32'd3);
    chk("tie_dst",   32'(move_dst),   32'd11);
    chk("tie_score", 32'(move_score), 32'd4);
    tick();

    // All-zero scores: no legal move.
    pulse_start(5'd2);
    do_pass(6'd0, 6'd5, 6'd6);
    do_pass(6'd0, 6'd7, 6'd9);
    chk("zero_valid",   32'(move_valid), 32'd1);
    chk("zero_no_move", 32'(no_move),    32'd1);
    chk("zero_score",   32'(move_score), 32'd0);
    chk("zero_src",     32'(move_src),   32'd0);
    tick();

    // Backpressure with a stray start in the window.
    move_ready = 1'b0;
    pulse_start(5'd1);
    do_pass(6'd6, 6'd2, 6'd40);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(move_valid), 32'd1);
      chk("bp_src",   32'(move_src),   32'd2);
      chk("bp_dst",   32'(move_dst),   32'd40);
      chk("bp_score", 32'(move_score), 32'd6);
      if (i == 2) begin
        start = 1'b1;
        num_passes = 5'd3;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("bp_still_valid", 32'(move_valid), 32'd1);
    chk("bp_no_req",      32'(pass_req),   32'd0);
    move_ready = 1'b1;
    tick();
    chk("bp_accept_valid", 32'(move_valid), 32'd0);
    chk("bp_accept_busy",  32'(busy),       32'd0);
    tick();
    chk("bp_idle_no_req",  32'(pass_req),   32'd0);

    // N == 0: immediate no_move at cycle 1.
    pulse_start(5'd0);
    chk("n0_valid",   32'(move_valid), 32'd1);
    chk("n0_no_move", 32'(no_move),    32'd1);
    chk("n0_req",     32'(pass_req),   32'd0);
    tick();
    chk("n0_done",    32'(busy),       32'd0);

    // num_passes = 20 clamps to 16 passes, idx 0..15.
    pulse_start(5'd20);
    for (int i = 0; i < 16; i++) begin
      chk("clamp_req", 32'(pass_req), 32'd1);
      chk("clamp_idx", 32'(pass_idx), 32'(i));
      do_pass(6'(i + 1), 6'(i), 6'(i + 20));
    end
    chk("clamp_no_17th", 32'(pass_req),   32'd0);
    chk("clamp_valid",   32'(move_valid), 32'd1);
    chk("clamp_score",   32'(move_score), 32'd16);
    chk("clamp_src",     32'(move_src),   32'd15);
    chk("clamp_dst",     32'(move_dst),   32'd35);
    tick();

    // Abort while waiting on pass index 2.
    pulse_start(5'd3);
    do_pass(6'd5, 6'd1, 6'd2);
    do_pass(6'd3, 6'd7, 6'd8);
    tick();
    chk("ab_wait_idx", 32'(pass_idx), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy",  32'(busy),       32'd0);
    chk("ab_req",   32'(pass_req),   32'd0);
    chk("ab_valid", 32'(move_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ab_stay_valid", 32'(move_valid), 32'd0);
    end

    // Stray strobes in IDLE and REQ.
    arb_valid = 1'b1; arb_score = 6'd63; arb_src = 6'd9; arb_pos = 6'd9;
    tick();
    tick();
    arb_valid = 1'b0;
    chk("stray_idle_busy", 32'(busy),     32'd0);
    chk("stray_idle_req",  32'(pass_req), 32'd0);
    pulse_start(5'd1);
    arb_valid = 1'b1; arb_score = 6'd60; arb_src = 6'd9; arb_pos = 6'd9;
    tick();
    arb_valid = 1'b0;
    chk("stray_req_wait", 32'(busy), 32'd1);
    chk("stray_req_nov",  32'(move_valid), 32'd0);
    arb_valid = 1'b1; arb_score = 6'd3; arb_src = 6'd4; arb_pos = 6'd5;
    tick();
    arb_valid = 1'b0;
    chk("stray_valid", 32'(move_valid), 32'd1);
    chk("stray_score", 32'(move_score), 32'd3);
    chk("stray_src",   32'(move_src),   32'd4);
    chk("stray_dst",   32'(move_dst),   32'd5);
    tick();

    // Asynchronous reset mid-WAIT.
    pulse_start(5'd2);
    tick();
    chk("rw_in_wait", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_busy",  32'(busy),       32'd0);
    chk("rw_req",   32'(pass_req),   32'd0);
    chk("rw_valid", 32'(move_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rw_no_req",  32'(pass_req), 32'd0);
      chk("rw_no_busy", 32'(busy),     32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
